// File: rtl/lab8_monitor.sv
// Observer for the lab8 Gray-coded SET/CLR sequencer: predicts each next state,
// flags deviations, decodes the state to binary and counts natural wraps.
module lab8_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        state,
  input  logic              SET,
  input  logic              CLR,
  output logic [1:0]        bin,
  output logic              locked,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wraps
);
  localparam logic [1:0] S0 = 2'b00, S1 = 2'b01, S2 = 2'b11, S3 = 2'b10;

  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  lock_t             lock_q, lock_nxt;
  logic [1:0]        smp, prev_state, pred;
  logic              prev_set, prev_clr;
  logic              bad_q, bad_nxt;
  logic              mis_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic [WRAP_W-1:0] wraps_nxt;

  // Positional copy into a descending vector; state[0] is the MSB.
  assign smp    = state;
  assign locked = (lock_q == LOCKED);

  always_comb begin
    pred = S0;
    if (prev_clr)      pred = S0;
    else if (prev_set) pred = S2;
    else begin
      case (prev_state)
        S0:      pred = S1;
        S1:      pred = S2;
        S2:      pred = S3;
        default: pred = S0;
      endcase
    end
  end

  always_comb begin
    lock_nxt  = lock_q;
    bad_nxt   = bad_q;
    mis_nxt   = 1'b0;
    err_nxt   = err_cnt;
    wraps_nxt = wraps;
    case (lock_q)
      UNLOCKED: lock_nxt = LOCKED;
      default: begin
        // Written as match-else so an unknown sample falls into the mismatch path.
        if (smp == pred) begin
          bad_nxt = 1'b0;
          if (prev_state == S3 && !prev_set && !prev_clr && smp == S0 && wraps != '1)
            wraps_nxt = wraps + 1'b1;
        end else begin
          mis_nxt = 1'b1;
          if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
          if (bad_q) begin
            lock_nxt = UNLOCKED;
            bad_nxt  = 1'b0;
          end else begin
            bad_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= UNLOCKED;
      bad_q      <= 1'b0;
      prev_state <= S0;
      prev_set   <= 1'b0;
      prev_clr   <= 1'b0;
      bin        <= 2'd0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
      wraps      <= '0;
    end else begin
      lock_q     <= lock_nxt;
      bad_q      <= bad_nxt;
      prev_state <= smp;
      prev_set   <= SET;
      prev_clr   <= CLR;
      bin        <= {smp[1], smp[1] ^ smp[0]};
      mismatch   <= mis_nxt;
      err_cnt    <= err_nxt;
      wraps      <= wraps_nxt;
    end
  end
endmodule

// File: tb/tb_lab8_monitor.sv
// Directed bench for lab8_monitor: one task per scenario, inline checks.
module tb_lab8_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:1] state = 2'b00;
  logic       SET = 1'b0, CLR = 1'b0;
  logic [1:0] bin;
  logic       locked, mismatch;
  logic [3:0] err_cnt;
  logic [7:0] wraps;

  int tests = 0;
  int fails = 0;

  lab8_monitor #(.WRAP_W(8), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .state(state), .SET(SET), .CLR(CLR),
    .bin(bin), .locked(locked), .mismatch(mismatch), .err_cnt(err_cnt), .wraps(wraps)
  );

  always #5 clk = ~clk;

  // Present one sample, let the DUT take it, then settle past the edge.
  task automatic step(input logic [1:0] st, input logic s, input logic c);
    @(negedge clk);
    state = st; SET = s; CLR = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2'b10, 1'b1, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    tests++; if (bin !== 2'd0) begin fails++; $display("FAIL reset_bin got %0d want 0", bin); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b want 0", locked); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL reset_err got %0d want 0", err_cnt); end
    tests++; if (wraps !== 8'd0) begin fails++; $display("FAIL reset_wraps got %0d want 0", wraps); end
    reset = 1'b0;
  endtask

  task automatic test_clean_cycle();
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] exp_bin [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0, 1'b0);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clean_locked[%0d] got %b want 1", i, locked); end
      tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL clean_mis[%0d] got %b want 0", i, mismatch); end
      tests++; if (bin !== exp_bin[i]) begin fails++; $display("FAIL clean_bin[%0d] got %0d want %0d", i, bin, exp_bin[i]); end
    end
    tests++; if (wraps !== 8'd1) begin fails++; $display("FAIL clean_wraps got %0d want 1", wraps); end
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL clean_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_set_clr_paths();
    logic [1:0] st [12] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10,
                           2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
    logic       sv [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    logic       cv [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    step(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(st[i], sv[i], cv[i]);
      tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL paths_mis[%0d] got %b want 0", i, mismatch); end
    end
    tests++; if (wraps !== 8'd0) begin fails++; $display("FAIL paths_wraps got %0d want 0", wraps); end
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL paths_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_single_fault();
    do_reset();
    step(2'b00, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL single_mis got %b want 1", mismatch); end
    tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL single_err got %0d want 1", err_cnt); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_locked got %b want 1", locked); end
    step(2'b00, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL single_mis_after got %b want 0", mismatch); end
    tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL single_err_after got %0d want 1", err_cnt); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_locked_after got %b want 1", locked); end
  endtask

  task automatic test_double_fault();
    do_reset();
    step(2'b00, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL double_mis1 got %b want 1", mismatch); end
    step(2'b01, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL double_mis2 got %b want 1", mismatch); end
    tests++; if (err_cnt !== 4'd2) begin fails++; $display("FAIL double_err got %0d want 2", err_cnt); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL double_unlocked got %b want 0", locked); end
    step(2'b11, 1'b0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL double_relock got %b want 1", locked); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL double_mis_relock got %b want 0", mismatch); end
    step(2'b10, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL double_mis_s3 got %b want 0", mismatch); end
    step(2'b00, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL double_mis_s0 got %b want 0", mismatch); end
    tests++; if (err_cnt !== 4'd2) begin fails++; $display("FAIL double_err_final got %0d want 2", err_cnt); end
  endtask

  task automatic test_saturation();
    int seen = 0;
    do_reset();
    step(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 1'b0, 1'b0);
      if (mismatch === 1'b1) seen++;
      step(2'b01, 1'b0, 1'b0);
      if (mismatch === 1'b1) seen++;
      step(2'b00, 1'b0, 1'b0);
      if (mismatch === 1'b1) seen++;
    end
    tests++; if (seen !== 20) begin fails++; $display("FAIL sat_pulses got %0d want 20", seen); end
    tests++; if (err_cnt !== 4'd15) begin fails++; $display("FAIL sat_err got %0d want 15", err_cnt); end
    for (int i = 0; i < 300; i++) begin
      step(2'b01, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      if (i == 254) begin
        tests++; if (wraps !== 8'd255) begin fails++; $display("FAIL sat_wraps_255 got %0d want 255", wraps); end
      end
    end
    tests++; if (wraps !== 8'd255) begin fails++; $display("FAIL sat_wraps_hold got %0d want 255", wraps); end
    tests++; if (err_cnt !== 4'd15) begin fails++; $display("FAIL sat_err_hold got %0d want 15", err_cnt); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    step(2'b00, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
    end
    tests++; if (err_cnt !== 4'd3) begin fails++; $display("FAIL mid_pre_err got %0d want 3", err_cnt); end
    tests++; if (wraps !== 8'd5) begin fails++; $display("FAIL mid_pre_wraps got %0d want 5", wraps); end
    reset = 1'b1;
    step(2'b11, 1'b0, 1'b0);
    reset = 1'b0;
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL mid_err got %0d want 0", err_cnt); end
    tests++; if (wraps !== 8'd0) begin fails++; $display("FAIL mid_wraps got %0d want 0", wraps); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL mid_mis got %b want 0", mismatch); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_locked got %b want 0", locked); end
    tests++; if (bin !== 2'd0) begin fails++; $display("FAIL mid_bin got %0d want 0", bin); end
    step(2'b11, 1'b0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_relock got %b want 1", locked); end
    tests++; if (bin !== 2'd2) begin fails++; $display("FAIL mid_relock_bin got %0d want 2", bin); end
    step(2'b10, 1'b0, 1'b0);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL mid_after_mis got %b want 0", mismatch); end
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL mid_after_err got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_cycle();
    test_set_clr_paths();
    test_single_fault();
    test_double_fault();
    test_saturation();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lab8_monitor.md
# lab8_monitor

Receive-side checker for the lab8 Gray-coded SET/CLR sequencer. It samples the sequencer's 2-bit state output and the same SET/CLR controls the sequencer sees, predicts each next state, and flags any deviation. It also decodes the state to binary and counts natural wrap-arounds. It sits beside the sequencer in lab integration builds as a self-checking observer and never drives the sequencer.

## Interface
- WRAP_W, 8: width of the wrap counter; saturating.
- ERR_W, 4: width of the mismatch counter; saturating.

- clk  in  1  rising-edge clock, shared with the sequencer.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- state  in  [0:1]  observed sequencer state. Encoding: S0=00, S1=01, S2=11, S3=10.
- SET  in  1  sequencer SET input, observed.
- CLR  in  1  sequencer CLR input, observed.
- bin  out  [1:0]  binary decode of the last sampled state: S0→0, S1→1, S2→2, S3→3.
- locked  out  1  high while the monitor holds a valid prediction reference.
- mismatch  out  1  one-cycle pulse; observed state differed from the predicted state.
- err_cnt  out  [ERR_W-1:0]  total mismatches, saturates at all-ones.
- wraps  out  [WRAP_W-1:0]  confirmed S3→S0 advances with SET=CLR=0, saturates at all-ones.

## Operation
- Sequencer next-state function, which the monitor reproduces:
  - CLR=1 → S0. CLR has priority, so SET=CLR=1 → S0.
  - Else SET=1 → S2, from every state. S2 with SET=1 stays in S2.
  - Else advance S0→S1→S2→S3→S0.
- Internal registers:
  - prev_state, prev_set, prev_clr.
  - One bad-in-a-row flag.
  - Lock FSM with two states, UNLOCKED and LOCKED.
- UNLOCKED, the reset state, on each edge:
  - Capture state, SET and CLR into the prev registers.
  - Go to LOCKED.
  - No compare; mismatch stays 0.
- LOCKED, on each edge:
  - Compute predicted = next(prev_state, prev_set, prev_clr) and compare it with the sampled state.
  - Match: clear the bad flag. If prev_state=S3, prev_set=0, prev_clr=0 and the sample is S0, increment wraps (saturating).
  - Mismatch: assert mismatch next cycle and increment err_cnt (saturating).
    - If the bad flag is already set, go to UNLOCKED and clear the flag.
    - Otherwise set the flag.
  - In every case, load prev_* from the current sample. After one bad sample the reference is the observed value, not the predicted one.
- bin is registered from the sample every cycle in both lock states.
- Saturated counters hold their value; they never wrap to 0.
- An X or Z on state counts as a mismatch. The bench does not rely on this.

## Timing
- Reset values, all outputs: bin=0, locked=0, mismatch=0, err_cnt=0, wraps=0. FSM returns to UNLOCKED and all prev_* registers and the bad flag are cleared.
- Reset asserted mid-operation overrides any compare on that edge. Counters do not increment on that edge.
- Alignment of a sample taken at edge k:
  - The sample is the sequencer output produced at edge k-1.
  - The prediction for it uses state, SET and CLR sampled at edge k-1.
- Latency: bin, mismatch, err_cnt and wraps all update at the same edge that samples state, so outputs are one cycle behind the sequencer.
- mismatch is exactly one cycle wide per bad sample. It is high on consecutive cycles only for consecutive bad samples.
- locked rises at the first edge after reset deasserts. It falls at the edge that detects the second consecutive mismatch, and rises again on the following edge.

## Test plan
- **Clean cycle.** Reset, then SET=CLR=0 and drive state 00,01,11,10,00 on successive edges.
  - locked=1 after edge 1; mismatch never asserts.
  - bin follows 0,1,2,3,0; wraps=1; err_cnt=0.
- **CLR and SET paths.**
  - From locked S2 with CLR=1, next state 00: no mismatch.
  - From S3 with SET=1, next 11: no mismatch.
  - From S2 with SET=1, next 11: no mismatch.
  - SET=CLR=1 from S1, next 00: no mismatch.
  - wraps stays 0 throughout.
- **Single fault.** Locked at S1 with SET=CLR=0, drive 10 instead of 11.
  - mismatch pulses for 1 cycle; err_cnt=1; locked stays 1.
  - Next sample 00, the advance from the new reference 10, gives no mismatch.
- **Double fault / relock.** Two consecutive wrong samples.
  - err_cnt=2; locked=0 for exactly one cycle, then 1.
  - A following correct sequence gives no further mismatch.
- **Saturation.** Force 20 mismatches, with relocks interleaved.
  - err_cnt holds at 15 (ERR_W=4).
  - Run 300 clean wraps: wraps holds at 255.
- **Reset mid-run.** Assert reset for 1 cycle while err_cnt=3 and wraps=5.
  - On the next edge all outputs are 0 and locked=0.
  - Relock occurs on the first edge after release.
